// File: rtl/mem_bank_if.sv
// Bus bundle for mem_bank_ctrl: read pair, write port, bulk-clear request and status.
interface mem_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              clr_req;
    logic              busy;
    logic              clr_done;

    modport master (
        output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data_a, rd_data_b, rd_valid, wr_done, busy, clr_done
    );

    modport slave (
        input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
        output rd_data_a, rd_data_b, rd_valid, wr_done, busy, clr_done
    );
endinterface

// File: rtl/mem_bank_ctrl.sv
// Dual-read / single-write data memory with write-first bypass and a sequential
// bulk-clear engine that also initialises the array after reset.
module mem_bank_ctrl #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_bank_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_n;
    logic              busy_q, busy_n;
    logic              rd_valid_q, rd_valid_n;
    logic              wr_done_q, wr_done_n;
    logic              clr_done_q, clr_done_n;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;
    logic [DATA_W-1:0] rd_next_a, rd_next_b;
    logic              rd_load;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEARING;
            clr_ptr    <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_n;
            clr_ptr    <= clr_ptr_n;
            busy_q     <= busy_n;
            rd_valid_q <= rd_valid_n;
            wr_done_q  <= wr_done_n;
            clr_done_q <= clr_done_n;
        end
    end

    // clr_req in IDLE pre-empts both the read and the write of that cycle.
    always_comb begin
        state_n    = state;
        clr_ptr_n  = clr_ptr;
        busy_n     = 1'b0;
        rd_valid_n = 1'b0;
        wr_done_n  = 1'b0;
        clr_done_n = 1'b0;
        rd_load    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.wr_data;
        unique case (state)
            CLEARING: begin
                busy_n    = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = CLEAR_VAL;
                if (clr_ptr == '1) begin
                    state_n    = IDLE;
                    busy_n     = 1'b0;
                    clr_done_n = 1'b1;
                end else begin
                    clr_ptr_n = clr_ptr + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr_req) begin
                    state_n   = CLEARING;
                    busy_n    = 1'b1;
                    clr_ptr_n = '0;
                end else begin
                    rd_load    = bus.rd_en;
                    rd_valid_n = bus.rd_en;
                    mem_we     = bus.wr_en;
                    wr_done_n  = bus.wr_en;
                end
            end
            default: begin
                state_n = CLEARING;
                busy_n  = 1'b1;
            end
        endcase
    end

    // Write-first: a same-cycle write to the read address is forwarded per port.
    always_comb begin
        rd_next_a = mem[bus.rd_addr_a];
        rd_next_b = mem[bus.rd_addr_b];
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) rd_next_a = bus.wr_data;
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) rd_next_b = bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else if (rd_load) begin
            rd_data_a_q <= rd_next_a;
            rd_data_b_q <= rd_next_b;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.rd_data_a = rd_data_a_q;
    assign bus.rd_data_b = rd_data_b_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.busy      = busy_q;
    assign bus.clr_done  = clr_done_q;
endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Self-checking bench for mem_bank_ctrl: 16x16 (clear to 0) and 64x32 (clear to DEADBEEF) instances.
module tb_mem_bank_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_bank_if #(.DATA_W(16), .ADDR_W(4)) b16 ();
    mem_bank_if #(.DATA_W(32), .ADDR_W(6)) b32 ();

    mem_bank_ctrl #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'h0000)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
    );
    mem_bank_ctrl #(.DATA_W(32), .ADDR_W(6), .CLEAR_VAL(32'hDEADBEEF)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(b32)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] m16 [16];
    logic [31:0] m32 [64];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle16;
        b16.rd_en = 1'b0; b16.rd_addr_a = '0; b16.rd_addr_b = '0;
        b16.wr_en = 1'b0; b16.wr_addr = '0; b16.wr_data = '0; b16.clr_req = 1'b0;
    endtask

    task automatic idle32;
        b32.rd_en = 1'b0; b32.rd_addr_a = '0; b32.rd_addr_b = '0;
        b32.wr_en = 1'b0; b32.wr_addr = '0; b32.wr_data = '0; b32.clr_req = 1'b0;
    endtask

    task automatic test_reset;
        int cnt;
        int pulses;
        idle16; idle32;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (b16.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b exp 1", b16.busy); end
        n_cmp++; if (b16.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b exp 0", b16.rd_valid); end
        n_cmp++; if (b16.wr_done !== 1'b0) begin n_err++; $display("FAIL reset_wr_done: got %b exp 0", b16.wr_done); end
        n_cmp++; if (b16.clr_done !== 1'b0) begin n_err++; $display("FAIL reset_clr_done: got %b exp 0", b16.clr_done); end
        n_cmp++; if (b16.rd_data_a !== 16'h0 || b16.rd_data_b !== 16'h0) begin
            n_err++; $display("FAIL reset_rd_data: got %h/%h exp 0000/0000", b16.rd_data_a, b16.rd_data_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0; pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            cnt++;
            if (b16.clr_done === 1'b1) pulses++;
            if (b16.busy !== 1'b1) break;
        end
        repeat (2) begin tick; if (b16.clr_done === 1'b1) pulses++; end
        n_cmp++; if (cnt != 16) begin n_err++; $display("FAIL reset_clear_len: got %0d exp 16", cnt); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL reset_clr_done_pulses: got %0d exp 1", pulses); end
        for (int a = 0; a < 16; a++) m16[a] = 16'h0000;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd0; b16.rd_addr_b = 4'd15;
        tick;
        n_cmp++; if (b16.rd_valid !== 1'b1) begin n_err++; $display("FAIL reset_read_valid: got %b exp 1", b16.rd_valid); end
        n_cmp++; if (b16.rd_data_a !== m16[0] || b16.rd_data_b !== m16[15]) begin
            n_err++; $display("FAIL reset_read_data: got %h/%h exp %h/%h", b16.rd_data_a, b16.rd_data_b, m16[0], m16[15]);
        end
        idle16;
        tick;
        n_cmp++; if (b16.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_read_drop: got %b exp 0", b16.rd_valid); end
    endtask

    task automatic test_write_read;
        b16.wr_en = 1'b1; b16.wr_addr = 4'd3; b16.wr_data = 16'h1234;
        tick; m16[3] = 16'h1234;
        n_cmp++; if (b16.wr_done !== 1'b1) begin n_err++; $display("FAIL wr_done_1: got %b exp 1", b16.wr_done); end
        b16.wr_addr = 4'd7; b16.wr_data = 16'hBEEF;
        tick; m16[7] = 16'hBEEF;
        n_cmp++; if (b16.wr_done !== 1'b1) begin n_err++; $display("FAIL wr_done_2: got %b exp 1", b16.wr_done); end
        idle16;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd3; b16.rd_addr_b = 4'd7;
        tick;
        n_cmp++; if (b16.wr_done !== 1'b0) begin n_err++; $display("FAIL wr_done_drop: got %b exp 0", b16.wr_done); end
        n_cmp++; if (b16.rd_valid !== 1'b1 || b16.rd_data_a !== 16'h1234 || b16.rd_data_b !== 16'hBEEF) begin
            n_err++; $display("FAIL rd_3_7: got v=%b %h/%h exp v=1 1234/beef", b16.rd_valid, b16.rd_data_a, b16.rd_data_b);
        end
        idle16;
        tick;
        n_cmp++; if (b16.rd_valid !== 1'b0 || b16.rd_data_a !== 16'h1234 || b16.rd_data_b !== 16'hBEEF) begin
            n_err++; $display("FAIL rd_hold: got v=%b %h/%h exp v=0 1234/beef", b16.rd_valid, b16.rd_data_a, b16.rd_data_b);
        end
    endtask

    task automatic test_bypass;
        b16.wr_en = 1'b1; b16.wr_addr = 4'd5; b16.wr_data = 16'h00AA;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd5; b16.rd_addr_b = 4'd5;
        tick; m16[5] = 16'h00AA;
        n_cmp++; if (b16.rd_data_a !== 16'h00AA || b16.rd_data_b !== 16'h00AA) begin
            n_err++; $display("FAIL bypass_both: got %h/%h exp 00aa/00aa", b16.rd_data_a, b16.rd_data_b);
        end
        n_cmp++; if (b16.wr_done !== 1'b1 || b16.rd_valid !== 1'b1) begin
            n_err++; $display("FAIL bypass_pulses: got wd=%b rv=%b exp 1/1", b16.wr_done, b16.rd_valid);
        end
        idle16;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd5; b16.rd_addr_b = 4'd3;
        tick;
        n_cmp++; if (b16.rd_data_a !== m16[5] || b16.rd_data_b !== m16[3]) begin
            n_err++; $display("FAIL bypass_commit: got %h/%h exp %h/%h", b16.rd_data_a, b16.rd_data_b, m16[5], m16[3]);
        end
        idle16;
    endtask

    task automatic test_random;
        logic [15:0] ea, eb, wd;
        logic [3:0]  ra, rb, wa;
        logic        re, we;
        ea = '0; eb = '0;
        for (int i = 0; i < 300; i++) begin
            re = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            ra = (i % 2 == 1) ? wa : 4'($urandom_range(0, 15));
            rb = (i % 3 == 0) ? wa : 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            b16.rd_en = re; b16.rd_addr_a = ra; b16.rd_addr_b = rb;
            b16.wr_en = we; b16.wr_addr = wa; b16.wr_data = wd;
            if (re) begin
                ea = (we && wa == ra) ? wd : m16[ra];
                eb = (we && wa == rb) ? wd : m16[rb];
            end
            tick;
            if (we) m16[wa] = wd;
            n_cmp++; if (b16.rd_valid !== re || b16.wr_done !== we) begin
                n_err++; $display("FAIL rand_pulses[%0d]: got rv=%b wd=%b exp %b/%b", i, b16.rd_valid, b16.wr_done, re, we);
            end
            n_cmp++; if (b16.rd_data_a !== ea || b16.rd_data_b !== eb) begin
                n_err++; $display("FAIL rand_data[%0d]: got %h/%h exp %h/%h", i, b16.rd_data_a, b16.rd_data_b, ea, eb);
            end
        end
        idle16;
    endtask

    task automatic test_clear;
        logic [15:0] ha, hb;
        int cnt;
        int bad;
        for (int a = 0; a < 16; a++) begin
            b16.wr_en = 1'b1; b16.wr_addr = 4'(a); b16.wr_data = 16'($urandom) | 16'h0100;
            m16[a] = b16.wr_data;
            tick;
        end
        idle16;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd0; b16.rd_addr_b = 4'd1;
        tick;
        ha = m16[0]; hb = m16[1];
        n_cmp++; if (b16.rd_data_a !== ha || b16.rd_data_b !== hb) begin
            n_err++; $display("FAIL fill_read: got %h/%h exp %h/%h", b16.rd_data_a, b16.rd_data_b, ha, hb);
        end
        b16.clr_req = 1'b1; b16.wr_en = 1'b1; b16.wr_addr = 4'd2; b16.wr_data = 16'hFFFF;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd2; b16.rd_addr_b = 4'd2;
        tick;
        n_cmp++; if (b16.wr_done !== 1'b0 || b16.rd_valid !== 1'b0 || b16.busy !== 1'b1) begin
            n_err++; $display("FAIL clr_priority: got wd=%b rv=%b busy=%b exp 0/0/1", b16.wr_done, b16.rd_valid, b16.busy);
        end
        n_cmp++; if (b16.rd_data_a !== ha || b16.rd_data_b !== hb) begin
            n_err++; $display("FAIL clr_priority_hold: got %h/%h exp %h/%h", b16.rd_data_a, b16.rd_data_b, ha, hb);
        end
        cnt = 1; bad = 0;
        for (int i = 0; i < 100; i++) begin
            b16.rd_en = 1'($urandom_range(0, 1)); b16.wr_en = 1'($urandom_range(0, 1));
            b16.clr_req = 1'($urandom_range(0, 1));
            b16.rd_addr_a = 4'($urandom_range(0, 15)); b16.rd_addr_b = 4'($urandom_range(0, 15));
            b16.wr_addr = 4'($urandom_range(0, 15)); b16.wr_data = 16'($urandom);
            tick;
            if (b16.rd_valid !== 1'b0 || b16.wr_done !== 1'b0 || b16.rd_data_a !== ha || b16.rd_data_b !== hb) bad++;
            if (b16.busy !== 1'b1) break;
            if (b16.clr_done !== 1'b0) bad++;
            cnt++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clr_ignore: got %0d responses exp 0", bad); end
        n_cmp++; if (cnt != 16) begin n_err++; $display("FAIL clr_len: got %0d exp 16", cnt); end
        n_cmp++; if (b16.clr_done !== 1'b1) begin n_err++; $display("FAIL clr_done_pulse: got %b exp 1", b16.clr_done); end
        idle16;
        tick;
        n_cmp++; if (b16.clr_done !== 1'b0 || b16.busy !== 1'b0) begin
            n_err++; $display("FAIL clr_done_drop: got cd=%b busy=%b exp 0/0", b16.clr_done, b16.busy);
        end
        for (int a = 0; a < 16; a++) m16[a] = 16'h0000;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            b16.rd_en = 1'b1; b16.rd_addr_a = 4'(a); b16.rd_addr_b = 4'(15 - a);
            tick;
            if (b16.rd_data_a !== m16[a] || b16.rd_data_b !== m16[15 - a] || b16.rd_valid !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clr_contents: got %0d bad reads exp 0", bad); end
        idle16;
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        int pulses;
        b16.wr_en = 1'b1; b16.wr_addr = 4'd1; b16.wr_data = 16'h5A5A;
        tick; m16[1] = 16'h5A5A;
        idle16;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd1; b16.rd_addr_b = 4'd1;
        tick;
        n_cmp++; if (b16.rd_data_a !== 16'h5A5A) begin n_err++; $display("FAIL mid_pre_read: got %h exp 5a5a", b16.rd_data_a); end
        idle16;
        b16.clr_req = 1'b1;
        tick;
        idle16;
        pulses = 0;
        repeat (9) begin tick; if (b16.clr_done === 1'b1) pulses++; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (b16.rd_data_a !== 16'h0 || b16.rd_data_b !== 16'h0 || b16.busy !== 1'b1 || b16.rd_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_outputs: got %h/%h busy=%b rv=%b exp 0000/0000 1 0",
                b16.rd_data_a, b16.rd_data_b, b16.busy, b16.rd_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            cnt++;
            if (b16.clr_done === 1'b1) pulses++;
            if (b16.busy !== 1'b1) break;
        end
        tick;
        if (b16.clr_done === 1'b1) pulses++;
        n_cmp++; if (cnt != 16) begin n_err++; $display("FAIL mid_restart_len: got %0d exp 16", cnt); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL mid_clr_done_pulses: got %0d exp 1", pulses); end
        for (int a = 0; a < 16; a++) m16[a] = 16'h0000;
        b16.rd_en = 1'b1; b16.rd_addr_a = 4'd1; b16.rd_addr_b = 4'd15;
        tick;
        n_cmp++; if (b16.rd_data_a !== m16[1] || b16.rd_data_b !== m16[15]) begin
            n_err++; $display("FAIL mid_contents: got %h/%h exp %h/%h", b16.rd_data_a, b16.rd_data_b, m16[1], m16[15]);
        end
        idle16;
    endtask

    task automatic test_wide;
        int cnt;
        int pulses;
        logic [31:0] wd;
        idle32;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0; pulses = 0;
        for (int i = 0; i < 200; i++) begin
            tick;
            cnt++;
            if (b32.clr_done === 1'b1) pulses++;
            if (b32.busy !== 1'b1) break;
        end
        tick;
        if (b32.clr_done === 1'b1) pulses++;
        n_cmp++; if (cnt != 64) begin n_err++; $display("FAIL wide_clear_len: got %0d exp 64", cnt); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL wide_clr_done_pulses: got %0d exp 1", pulses); end
        for (int a = 0; a < 64; a++) m32[a] = 32'hDEADBEEF;
        b32.rd_en = 1'b1; b32.rd_addr_a = 6'd63; b32.rd_addr_b = 6'd0;
        tick;
        n_cmp++; if (b32.rd_data_a !== m32[63] || b32.rd_data_b !== m32[0]) begin
            n_err++; $display("FAIL wide_clear_val: got %h/%h exp %h/%h", b32.rd_data_a, b32.rd_data_b, m32[63], m32[0]);
        end
        idle32;
        b32.wr_en = 1'b1; b32.wr_addr = 6'd40; b32.wr_data = 32'h89ABCDEF;
        tick; m32[40] = 32'h89ABCDEF;
        n_cmp++; if (b32.wr_done !== 1'b1) begin n_err++; $display("FAIL wide_wr_done: got %b exp 1", b32.wr_done); end
        idle32;
        b32.rd_en = 1'b1; b32.rd_addr_a = 6'd40; b32.rd_addr_b = 6'd41;
        tick;
        n_cmp++; if (b32.rd_data_a !== m32[40] || b32.rd_data_b !== m32[41]) begin
            n_err++; $display("FAIL wide_roundtrip: got %h/%h exp %h/%h", b32.rd_data_a, b32.rd_data_b, m32[40], m32[41]);
        end
        wd = $urandom;
        b32.wr_en = 1'b1; b32.wr_addr = 6'd63; b32.wr_data = wd;
        b32.rd_en = 1'b1; b32.rd_addr_a = 6'd63; b32.rd_addr_b = 6'd40;
        tick; m32[63] = wd;
        n_cmp++; if (b32.rd_data_a !== wd || b32.rd_data_b !== m32[40]) begin
            n_err++; $display("FAIL wide_bypass: got %h/%h exp %h/%h", b32.rd_data_a, b32.rd_data_b, wd, m32[40]);
        end
        idle32;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_write_read;
        test_bypass;
        test_random;
        test_clear;
        test_reset_mid_clear;
        test_wide;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
